reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Consumes the board-level power-on reset `rstb` and releases N downstream reset domains one at a time, in a fixed order.
- Each stage is released only after the previous stage reports ready (e.g. PLL lock, DDR calibration, SRU link up). Each wait is bounded by a timeout.
- Sits directly below the power-on reset generator in the system clock domain. Its outputs drive the `rstb` ports of downstream APZ/FEC sub-systems.

Parameters:
- N_STAGES, 4, number of sequenced reset domains (1..8).
- STAGE_W, 2, width of the stage index; must equal clog2(N_STAGES), minimum 1.
- HOLD_CYCLES, 26, number of clk cycles all stages are held in reset before stage 0 is released (minimum 1).
- TIMEOUT_CYCLES, 65535, maximum number of clk cycles to wait for a stage's ready after releasing it.
- CNT_W, 16, counter width; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock.
- rstb  in  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is already synchronous to clk.
- sw_rst_req  in  1  single-cycle software re-sequence request, synchronous to clk.
- stage_ready  in  N_STAGES  per-stage ready/lock; may be asynchronous.
- stage_rstb  out  N_STAGES  per-stage active-low reset, registered.
- all_ready  out  1  high when every stage is released and ready.
- busy  out  1  high while the sequence is in progress (states HOLD, RELEASE, WAIT).
- timeout_err  out  1  sticky error flag.
- fail_stage  out  STAGE_W  index of the stage that timed out or dropped ready.

Behaviour:
- Reset (rstb=0), asynchronous: stage_rstb=0, all_ready=0, busy=1, timeout_err=0, fail_stage=0, state=HOLD, counter=0, idx=0.
- stage_ready passes through a 2-flop synchronizer per bit, reset to 0. All ready decisions use the synchronized value rdy_s. Synchronizer latency is 2 cycles.
- HOLD state:
  - All stage_rstb=0; counter increments each cycle.
  - When counter==HOLD_CYCLES-1: counter:=0, idx:=0, go to RELEASE.
  - Timing: stage_rstb[0] rises exactly HOLD_CYCLES+1 rising edges after the first edge with rstb=1.
- RELEASE state (one cycle): stage_rstb[idx]:=1, counter:=0, go to WAIT.
- WAIT state:
  - If rdy_s[idx]=1:
    - idx==N_STAGES-1: go to DONE.
    - Otherwise: idx:=idx+1, go to RELEASE. The next stage is released 2 cycles after rdy_s is seen.
  - Else if counter==TIMEOUT_CYCLES-1: go to ERR, timeout_err:=1, fail_stage:=idx.
  - Otherwise counter increments.
  - If rdy_s[idx] and the timeout condition are true in the same cycle, ready wins.
- DONE state:
  - all_ready=1, busy=0, all stage_rstb=1.
  - If any rdy_s[k] drops: fail_stage:=lowest such k, timeout_err unchanged, all_ready:=0, go to HOLD (full re-sequence).
- ERR state:
  - busy=0, all_ready=0.
  - Stages 0..fail_stage-1 stay released; stage fail_stage and all later stages are held at 0.
  - Remains in ERR until sw_rst_req or rstb.
- sw_rst_req: honoured in every state.
  - Next edge: all stage_rstb:=0, counter:=0, idx:=0, timeout_err:=0, fail_stage:=0, state:=HOLD.
  - It has priority over every other transition in the same cycle.
  - A request during HOLD restarts the hold count.
- Ready handling:
  - Ready bits of stages not yet released are ignored.
  - A ready already high when its stage is released is accepted on the first WAIT cycle.
- rstb asserted mid-sequence: all outputs return to their reset values immediately (asynchronously).
- Width rules:
  - Counters are unsigned CNT_W-bit and never wrap, because the compare terminates them.
  - idx is compared as STAGE_W bits against N_STAGES-1.

Decomposition:
- Shared package `sys_rst_pkg`:
  - state enum: HOLD, RELEASE, WAIT, DONE, ERR;
  - default constants HOLD_CYCLES_DEF=26 and TIMEOUT_CYCLES_DEF=65535;
  - function clog2.
- One sub-module, `sync_2ff`: parameterised width, asynchronous active-low reset, reset value 0. It is instantiated once for stage_ready.

Test Plan:
- Power-up, HOLD=26, N=4, all stage_ready tied to 1 → stage_rstb[0] rises at edge 27. Stages 1, 2, 3 rise at 2-cycle spacing, then all_ready=1 and busy=0.
- stage_ready[2] held at 0, TIMEOUT=100 → timeout_err=1, fail_stage=2, stage_rstb=4'b0011, busy=0, all_ready=0. It holds these values indefinitely.
- From ERR, pulse sw_rst_req → next edge stage_rstb=0, timeout_err=0, HOLD restarts. With all ready=1 the sequence completes again.
- In DONE, drop stage_ready[1] for 5 cycles → all_ready falls 3 cycles later, fail_stage=1, all stage_rstb=0, and a full re-sequence follows.
- Assert rstb=0 between clock edges while in WAIT on stage 1 → stage_rstb=0 and busy=1 immediately, without waiting for a clock edge. Release rstb → the timing of the first test repeats.
- sw_rst_req in the same cycle as rdy_s[idx] rising in WAIT → sw_rst_req wins: state=HOLD and idx stays 0.

Source files
------------

// File: rtl/sys_rst_pkg.sv
// Shared types and defaults for the board reset sequencer.
package sys_rst_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    WAIT,
    DONE,
    ERR
  } state_t;

  localparam int HOLD_CYCLES_DEF    = 26;
  localparam int TIMEOUT_CYCLES_DEF = 65535;

  // Ceiling log2 with a floor of 1 so a single-stage build still gets a 1-bit index.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bank for asynchronous level inputs; clears to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives a settled copy.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream reset domains one at a time after a hold period,
// waiting (bounded) for each domain's ready before releasing the next.
module reset_sequencer
  import sys_rst_pkg::*;
#(
  parameter int N_STAGES       = 4,
  parameter int STAGE_W        = clog2(N_STAGES),
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                sw_rst_req,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_rstb,
  output logic                all_ready,
  output logic                busy,
  output logic                timeout_err,
  output logic [STAGE_W-1:0]  fail_stage
);

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STAGE_W-1:0] IDX_LAST  = STAGE_W'(N_STAGES - 1);

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [STAGE_W-1:0]    idx, idx_nx;
  logic [N_STAGES-1:0]   rs_nx;
  logic                  err_nx;
  logic [STAGE_W-1:0]    fail_nx;

  logic [N_STAGES-1:0]   rdy_s;
  logic                  any_drop;
  logic [STAGE_W-1:0]    drop_idx;
  logic [N_STAGES-1:0]   keep_mask;

  sync_2ff #(.WIDTH(N_STAGES)) u_rdy_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (stage_ready),
    .q    (rdy_s)
  );

  // Lowest stage whose ready dropped, and the mask of stages below idx.
  always_comb begin
    any_drop  = ~&rdy_s;
    drop_idx  = '0;
    keep_mask = '0;
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      if (!rdy_s[k]) drop_idx = STAGE_W'(k);
    end
    for (int k = 0; k < N_STAGES; k++) begin
      keep_mask[k] = (STAGE_W'(k) < idx);
    end
  end

  // Next-state and next-register values; a software request overrides everything.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    rs_nx    = stage_rstb;
    err_nx   = timeout_err;
    fail_nx  = fail_stage;
    if (sw_rst_req) begin
      state_nx = HOLD;
      cnt_nx   = '0;
      idx_nx   = '0;
      rs_nx    = '0;
      err_nx   = 1'b0;
      fail_nx  = '0;
    end else begin
      case (state)
        HOLD: begin
          rs_nx = '0;
          if (cnt == HOLD_LAST) begin
            cnt_nx   = '0;
            idx_nx   = '0;
            state_nx = RELEASE;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          rs_nx[idx] = 1'b1;
          cnt_nx     = '0;
          state_nx   = WAIT;
        end
        WAIT: begin
          // Ready wins over a timeout landing in the same cycle.
          if (rdy_s[idx]) begin
            if (idx == IDX_LAST) begin
              state_nx = DONE;
            end else begin
              idx_nx   = idx + STAGE_W'(1);
              state_nx = RELEASE;
            end
          end else if (cnt == TO_LAST) begin
            state_nx = ERR;
            err_nx   = 1'b1;
            fail_nx  = idx;
            rs_nx    = keep_mask;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        DONE: begin
          rs_nx = '1;
          if (any_drop) begin
            fail_nx  = drop_idx;
            state_nx = HOLD;
            cnt_nx   = '0;
            idx_nx   = '0;
            rs_nx    = '0;
          end
        end
        ERR: begin
          // Parked until software or board reset.
        end
        default: begin
          state_nx = HOLD;
          cnt_nx   = '0;
          idx_nx   = '0;
          rs_nx    = '0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      stage_rstb  <= '0;
      timeout_err <= 1'b0;
      fail_stage  <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      stage_rstb  <= rs_nx;
      timeout_err <= err_nx;
      fail_stage  <= fail_nx;
    end
  end

  assign all_ready = (state == DONE);
  assign busy      = (state == HOLD) || (state == RELEASE) || (state == WAIT);

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: a timing model predicts every output change; a monitor
// compares each observed change against the predicted cycle and value.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int HOLD = 26;
  localparam int T    = 100;
  localparam int BIG  = 32'h3fff_ffff;

  typedef struct packed {
    logic [N-1:0] rs;
    logic         ar;
    logic         bz;
    logic         er;
    logic [1:0]   fs;
  } snap_t;

  typedef struct {
    int    c;
    snap_t s;
  } ev_t;

  logic         clk = 1'b0;
  logic         rstb;
  logic         sw_rst_req;
  logic [N-1:0] stage_ready;
  logic [N-1:0] stage_rstb;
  logic         all_ready, busy, timeout_err;
  logic [1:0]   fail_stage;

  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  ev_t   q[$];
  snap_t exp_cur, last_obs;
  int    mode[N];   // 0 ready already high, 1 ready rises dly after release, 2 never
  int    dly[N];
  int    rel[N];

  reset_sequencer #(
    .N_STAGES(N), .STAGE_W(2), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(T), .CNT_W(16)
  ) dut (
    .clk(clk), .rstb(rstb), .sw_rst_req(sw_rst_req), .stage_ready(stage_ready),
    .stage_rstb(stage_rstb), .all_ready(all_ready), .busy(busy),
    .timeout_err(timeout_err), .fail_stage(fail_stage)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  function automatic snap_t rst_snap();
    snap_t s;
    s    = '0;
    s.bz = 1'b1;
    return s;
  endfunction

  function automatic snap_t cur();
    return snap_t'({stage_rstb, all_ready, busy, timeout_err, fail_stage});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int c, input snap_t s);
    ev_t e;
    if (s != exp_cur) begin
      e.c = c;
      e.s = s;
      q.push_back(e);
      exp_cur = s;
    end
  endtask

  task automatic monitor();
    snap_t obs;
    ev_t   e;
    forever begin
      @(negedge clk);
      obs = cur();
      if (obs !== last_obs) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change@%0d: got out=%h want out=%h", cyc, obs, last_obs);
        end else begin
          e = q.pop_front();
          if (e.c != cyc || e.s !== obs) begin
            bad++;
            $display("FAIL event: got cyc=%0d out=%h want cyc=%0d out=%h", cyc, obs, e.c, e.s);
          end
        end
        last_obs = obs;
      end else if (q.size() > 0 && q[0].c < cyc) begin
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_change: got out=%h at cyc=%0d want cyc=%0d out=%h", obs, cyc, e.c, e.s);
      end
    end
  endtask

  // Timing model: from sequence start s, stage k is released HOLD+1 edges
  // later (first stage) or one edge after the previous ready was accepted.
  // A ready that rises d edges after release is seen 3 edges later (async
  // input plus two sync flops); a pre-high ready is taken on the next edge.
  task automatic plan(input int s, input int stop, output int fin);
    int    r, a;
    snap_t sn;
    fin = stop;
    for (int k = 0; k < N; k++) rel[k] = -1;
    r = s + HOLD + 1;
    for (int k = 0; k < N; k++) begin
      if (r > stop) return;
      sn = exp_cur;
      sn.rs[k] = 1'b1;
      push_exp(r, sn);
      rel[k] = r;
      if (mode[k] == 0)      a = r + 1;
      else if (mode[k] == 1) a = r + dly[k] + 3;
      else                   a = r + T + 1;
      if (a > r + T) begin
        if (r + T > stop) return;
        sn    = exp_cur;
        sn.rs = N'((1 << k) - 1);
        sn.bz = 1'b0;
        sn.er = 1'b1;
        sn.fs = 2'(k);
        push_exp(r + T, sn);
        fin = r + T;
        return;
      end
      if (k == N - 1) begin
        if (a > stop) return;
        sn    = exp_cur;
        sn.ar = 1'b1;
        sn.bz = 1'b0;
        push_exp(a, sn);
        fin = a;
        return;
      end
      r = a + 1;
    end
  endtask

  task automatic set_readies();
    for (int k = 0; k < N; k++) stage_ready[k] = (mode[k] == 0);
  endtask

  task automatic run_to(input int c);
    bit done;
    done = 1'b0;
    while (!done) begin
      for (int k = 0; k < N; k++)
        if (mode[k] == 1 && rel[k] >= 0 && cyc == rel[k] + dly[k]) stage_ready[k] = 1'b1;
      if (cyc >= c) done = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
    end
  endtask

  task automatic start_rstb(output int s);
    rstb = 1'b0;
    sw_rst_req = 1'b0;
    set_readies();
    push_exp(cyc, rst_snap());
    #1;
    chk("async_rstb_outputs", int'({stage_rstb, busy}), 1);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    rstb = 1'b1;
    s = cyc;
  endtask

  task automatic sw_pulse(output int s);
    sw_rst_req = 1'b1;
    @(posedge clk);
    #2;
    sw_rst_req = 1'b0;
    s = cyc;
  endtask

  task automatic start_sw(output int s);
    set_readies();
    sw_pulse(s);
    push_exp(s, rst_snap());
  endtask

  task automatic all_pre();
    for (int k = 0; k < N; k++) begin
      mode[k] = 0;
      dly[k]  = 0;
    end
  endtask

  initial begin
    int    s, s2, fin, x, e, ab;
    snap_t sn;
    rstb        = 1'b0;
    sw_rst_req  = 1'b0;
    stage_ready = '0;
    exp_cur     = rst_snap();
    last_obs    = rst_snap();
    all_pre();
    for (int k = 0; k < N; k++) rel[k] = -1;
    #3;
    chk("reset_stage_rstb", int'(stage_rstb), 0);
    chk("reset_all_ready", int'(all_ready), 0);
    chk("reset_busy", int'(busy), 1);
    chk("reset_timeout_err", int'(timeout_err), 0);
    chk("reset_fail_stage", int'(fail_stage), 0);
    fork
      monitor();
    join_none
    @(posedge clk);
    #2;

    // Power-up with every ready high.
    all_pre();
    start_rstb(s);
    plan(s, BIG, fin);
    run_to(fin + 8);
    chk("done_all_ready", int'(all_ready), 1);

    // Stage 2 never comes ready: timeout, then ERR holds.
    all_pre();
    mode[2] = 2;
    start_rstb(s);
    plan(s, BIG, fin);
    run_to(fin + 50);
    chk("err_stage_rstb", int'(stage_rstb), 3);
    chk("err_fail_stage", int'(fail_stage), 2);

    // Software re-sequence out of ERR.
    all_pre();
    start_sw(s);
    plan(s, BIG, fin);
    run_to(fin + 8);

    // Drop stage 1 ready for 5 cycles while DONE.
    e = cyc;
    stage_ready[1] = 1'b0;
    sn    = exp_cur;
    sn.rs = '0;
    sn.ar = 1'b0;
    sn.bz = 1'b1;
    sn.fs = 2'd1;
    push_exp(e + 3, sn);
    all_pre();
    plan(e + 3, BIG, fin);
    run_to(e + 5);
    stage_ready[1] = 1'b1;
    run_to(fin + 8);

    // Board reset while waiting on stage 1, then a clean power-up.
    all_pre();
    mode[1] = 2;
    start_rstb(s);
    ab = s + HOLD + 1 + 2 + 10;
    plan(s, ab, fin);
    run_to(ab);
    all_pre();
    start_rstb(s);
    plan(s, BIG, fin);
    run_to(fin + 8);

    // Software request in the same cycle stage 0 ready is first seen.
    all_pre();
    mode[0] = 1;
    dly[0]  = 5;
    start_rstb(s);
    x = s + HOLD + 1 + 5 + 3;
    plan(s, x - 1, fin);
    run_to(x - 1);
    sw_pulse(s2);
    chk("sw_edge", s2, x);
    push_exp(s2, rst_snap());
    mode[0] = 0;
    plan(s2, BIG, fin);
    run_to(fin + 8);

    // Software request during HOLD restarts the hold count.
    all_pre();
    start_rstb(s);
    plan(s, s + 10, fin);
    run_to(s + 10);
    sw_pulse(s2);
    push_exp(s2, rst_snap());
    plan(s2, BIG, fin);
    run_to(fin + 8);

    // Randomized ready timing, including the ready/timeout tie boundary.
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < N; k++) begin
        x = $urandom_range(0, 99);
        mode[k] = (x < 40) ? 0 : (x < 85) ? 1 : 2;
        dly[k]  = $urandom_range(0, 12);
        if ($urandom_range(0, 5) == 0) dly[k] = T - 3 + $urandom_range(0, 1);
      end
      if ($urandom_range(0, 1) == 1) start_sw(s);
      else                           start_rstb(s);
      plan(s, BIG, fin);
      run_to(fin + 8);
    end

    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
